// File: rtl/rr_stream_arbiter.sv
// Round-robin N_REQ:1 valid/ready stream arbiter with a single registered output slot.
// Optional burst holding of the grant is compiled in with `define ARB_BURST_EN.
module rr_stream_arbiter #(
  parameter int D_WIDTH   = 6,
  parameter int N_REQ     = 4,
  parameter int ID_WIDTH  = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*D_WIDTH-1:0]   up_data,
  input  logic [N_REQ-1:0]           up_valid,
  output logic [N_REQ-1:0]           up_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic [ID_WIDTH-1:0]        down_id,
  output logic                       down_valid,
  input  logic                       down_ready
);

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [D_WIDTH-1:0]  down_data_q, down_data_d;
  logic [ID_WIDTH-1:0] down_id_q, down_id_d;
  logic                down_valid_q, down_valid_d;

  logic [N_REQ-1:0]    grant_s;
  logic [ID_WIDTH-1:0] grant_id_s;
  logic [ID_WIDTH-1:0] idx_s;
  logic                grant_any_s;
  logic                out_free_s;
  logic                xfer_s;
  logic [D_WIDTH-1:0]  xfer_data_s;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_next_s;
`endif

  // Priority search starting at rr_ptr; ID arithmetic wraps because N_REQ is a power of two.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = rr_ptr_q;
    idx_s       = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = rr_ptr_q + ID_WIDTH'(k);
      if (!grant_any_s && up_valid[idx_s]) begin
        grant_any_s = 1'b1;
        grant_id_s  = idx_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s = N_REQ'(1) << grant_id_s;
    end else begin
      grant_s = '0;
    end
  end

  assign out_free_s  = !down_valid_q || down_ready;
  assign xfer_s      = grant_any_s && out_free_s && !rst;
  assign xfer_data_s = up_data[grant_id_s*D_WIDTH +: D_WIDTH];
  assign up_ready    = grant_s & {N_REQ{out_free_s && !rst}};

  // Output slot: load on upstream transfer, empty on drain-only, otherwise hold.
  always_comb begin
    down_data_d  = down_data_q;
    down_id_d    = down_id_q;
    down_valid_d = down_valid_q;
    if (xfer_s) begin
      down_data_d  = xfer_data_s;
      down_id_d    = grant_id_s;
      down_valid_d = 1'b1;
    end else if (down_ready) begin
      down_valid_d = 1'b0;
    end else begin
      down_valid_d = down_valid_q;
    end
  end

`ifdef ARB_BURST_EN
  // A burst continues only while the same requester wins back-to-back transfers.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (grant_id_s == down_id_q && burst_cnt_q != '0) begin
      burst_next_s = burst_cnt_q + CNT_W'(1);
    end else begin
      burst_next_s = CNT_W'(1);
    end
    if (xfer_s) begin
      if (burst_next_s >= CNT_W'(BURST_LEN)) begin
        rr_ptr_d    = grant_id_s + ID_WIDTH'(1);
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = grant_id_s;
        burst_cnt_d = burst_next_s;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end
`else
  // Pointer moves one past the winner after every transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_s) begin
      rr_ptr_d = grant_id_s + ID_WIDTH'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end
`endif

  // State registers with synchronous reset; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      down_data_q  <= '0;
      down_id_q    <= '0;
      down_valid_q <= 1'b0;
`ifdef ARB_BURST_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      down_data_q  <= down_data_d;
      down_id_q    <= down_id_d;
      down_valid_q <= down_valid_d;
`ifdef ARB_BURST_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  assign down_data  = down_data_q;
  assign down_id    = down_id_q;
  assign down_valid = down_valid_q;

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 6, is the data width of every stream.
REQ-002 Parameter N_REQ, default 4, is the number of upstream requesters (power of 2, 2..16).
REQ-003 Parameter ID_WIDTH, default 2, is the requester index width and SHALL equal log2(N_REQ).
REQ-004 Parameter BURST_LEN, default 4, is the maximum number of consecutive beats per grant (used only under ARB_BURST_EN).
REQ-005 clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-006 rst  input  1  is the synchronous, active-high reset.
REQ-007 up_data  input  N_REQ*D_WIDTH  is the packed requester data; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-008 up_valid  input  N_REQ  is the per-requester valid.
REQ-009 up_ready  output  N_REQ  is the per-requester ready.
REQ-010 down_data  output  D_WIDTH  is the arbitrated data, driven from a register.
REQ-011 down_id  output  ID_WIDTH  is the index of the requester that sourced down_data, driven from a register.
REQ-012 down_valid  output  1  is the downstream valid, driven from a register.
REQ-013 down_ready  input  1  is the downstream ready.

Function
REQ-014 A beat transfers on any interface only in a cycle where both valid and ready are high.
REQ-015 Output stage SHALL be a single register slot; out_free = !down_valid | down_ready.
REQ-016 Grant SHALL be combinational, one-hot or zero: the first requester with up_valid high, searching from rr_ptr upward modulo N_REQ.
REQ-017 up_ready[i] SHALL equal grant[i] & out_free; at most one up_ready bit is high per cycle.
REQ-018 On an upstream transfer from requester g, down_data <= up_data slice g, down_id <= g, down_valid <= 1 on the next edge (latency 1 cycle).
REQ-019 When down_valid & down_ready and there is no upstream transfer, down_valid SHALL go to 0; down_data and down_id hold.
REQ-020 Simultaneous downstream drain and upstream transfer SHALL replace the slot contents with no bubble, sustaining 1 beat/cycle.
REQ-021 While down_valid & !down_ready, down_data, down_id and down_valid SHALL hold, and all up_ready SHALL be 0.
REQ-022 Without ARB_BURST_EN, each upstream transfer from g SHALL set rr_ptr <= (g+1) mod N_REQ, with wrap-around from N_REQ-1 to 0.
REQ-023 With no up_valid high, grant SHALL be 0 and rr_ptr SHALL hold.
REQ-024 up_valid deasserting without a transfer SHALL NOT change rr_ptr.
REQ-025 A requester continuously valid SHALL be granted within N_REQ upstream transfers (starvation-free).

Reset
REQ-026 On rst high at a clock edge: down_valid <= 0, down_data <= 0, down_id <= 0, rr_ptr <= 0, burst_cnt <= 0; up_ready SHALL be 0 during that cycle.
REQ-027 Reset asserted mid-operation SHALL discard the beat held in the output slot; no beat is replayed after reset.

Configuration
REQ-028 Macro ARB_BURST_EN compiles in burst holding; absent, behaviour is pure per-beat round-robin per REQ-022.
REQ-029 With ARB_BURST_EN, after a transfer from g, burst_cnt increments and rr_ptr stays at g while burst_cnt < BURST_LEN.
REQ-030 With ARB_BURST_EN, on the BURST_LEN-th consecutive beat from g, rr_ptr <= (g+1) mod N_REQ and burst_cnt <= 0.
REQ-031 With ARB_BURST_EN, if the granted requester differs from the previous one, burst_cnt restarts at 1 for the new grant.
REQ-032 With ARB_BURST_EN, if up_valid[rr_ptr] is low in a cycle where another requester is valid, grant SHALL pass on per REQ-016.

Verification
REQ-033 Reset, up_valid=4'b1111, down_ready=1 (no macro) -> down_id sequence 0,1,2,3,0,..., down_valid high every cycle after the first.
REQ-034 up_valid=4'b0101, down_ready=1 -> down_id alternates 0,2,0,2; up_ready[1] and up_ready[3] stay 0.
REQ-035 Slot full, down_ready=0 for 3 cycles -> down_data/down_id stable and up_ready=0; down_ready=1 -> next beat follows with no bubble.
REQ-036 ARB_BURST_EN, BURST_LEN=4, all valid -> down_id 0,0,0,0,1,1,1,1,2,...
REQ-037 rst pulsed while down_valid=1 with data 6'h2A -> next cycle down_valid=0, down_data=0, first grant after reset goes to requester 0.
REQ-038 Only requester 3 valid, then only 0 valid -> ids 3 then 0; rr_ptr wraps 3 to 0 correctly.
